vector_checker: RTL

VECTOR_CHECKER -- requirements
Module: vector_checker

---
 rtl/vector_checker_pkg.sv | 11 +
 rtl/vec_fifo.sv | 40 ++++
 rtl/vector_checker.sv | 81 ++++++++
 3 files changed

// File: rtl/vector_checker_pkg.sv
// vector_checker_pkg: shared state, vector layout and counter width for the vector checker
package vector_checker_pkg;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [31:0] a;
    logic        b;
    logic        c;
    logic        last;
  } vec_t;
endpackage

// File: rtl/vec_fifo.sv
// vec_fifo: synchronous FIFO with flush and full/empty flags
module vec_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/vector_checker.sv
// vector_checker: compares sampled DUT outputs against a queue of expected vectors
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [31:0]      exp_a,
  input  logic             exp_b,
  input  logic             exp_c,
  input  logic             exp_last,
  input  logic             sample,
  input  logic [31:0]      dut_a,
  input  logic             dut_b,
  input  logic             dut_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             underflow,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);
  state_t state, state_nx;
  vec_t head;
  logic full, empty, start_run, push, pop, miss;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  assign start_run = start && state != RUN;
  assign push = exp_valid && exp_ready;
  assign pop = state == RUN && sample && !empty;
  assign miss = {dut_a, dut_b, dut_c} != {head.a, head.b, head.c};
  vec_fifo #(.DEPTH(DEPTH), .W($bits(vec_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (start_run),
    .push  (push),
    .pop   (pop),
    .din   ({exp_a, exp_b, exp_c, exp_last}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = start_run ? RUN : (pop && head.last) ? DONE : state;
  end
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
    exp_ready = rst_n && state != DONE && !full && !start;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || start_run) begin
      vec_count <= '0;
      err_count <= '0;
      first_err_idx <= '1;
      underflow <= 1'b0;
      pass <= 1'b0;
    end else if (state == RUN && sample) begin
      if (!empty) begin
        vec_count <= sat_inc(vec_count);
        if (miss) err_count <= sat_inc(err_count);
        if (miss && err_count == '0) first_err_idx <= vec_count;
        if (head.last) pass <= !miss && err_count == '0 && !underflow;
      end else begin
        underflow <= 1'b1;
        err_count <= sat_inc(err_count);
      end
    end
  end
endmodule
